// File: rtl/sub_serial_8bit.sv
// -----------------------------------------------------------------------------
// sub_serial_8bit
// Bit-serial two's-complement subtractor: diff = inA - inB (mod 2^WIDTH).
// The block processes one bit per clock, LSB first, through a single
// full-subtractor cell and a borrow flip-flop.
// Operands and results each use a valid/ready handshake.
//
// Optional feature macro: SUB_OVF_EN
//   defined   -> the overflow port and its signed-overflow flag are present
//   undefined -> no overflow port; all other behaviour is the same
// -----------------------------------------------------------------------------
module sub_serial_8bit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             zero
`ifdef SUB_OVF_EN
  ,
  output logic             overflow
`endif
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;     // minuend, shifted right one bit per SHIFT cycle
  logic [WIDTH-1:0] b_sh;     // subtrahend, shifted right in step with a_sh
  logic [WIDTH-1:0] r_sh;     // result; each new bit enters at the MSB
  logic [CW-1:0]    cnt;      // index of the bit being processed
  logic             bw;       // borrow carried between bit positions

  // Full-subtractor cell working on the current LSBs of the operand registers
  logic             a0;
  logic             b0;
  logic             d_bit;
  logic             bw_next;
  logic [WIDTH-1:0] r_next;

  assign a0      = a_sh[0];
  assign b0      = b_sh[0];
  assign d_bit   = a0 ^ b0 ^ bw;
  assign bw_next = (~a0 & b0) | (~(a0 ^ b0) & bw);
  // After WIDTH shifts the first bit entered has moved down to bit 0, so the
  // register holds the result in normal bit order.
  assign r_next  = {d_bit, r_sh[WIDTH-1:1]};

  // Control FSM, serial datapath and registered result/flags in one process
  // NOTE: every register here uses non-blocking assignment. This lets each
  // branch read the values from before the edge. An example is cnt in the
  // LAST_BIT test.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      a_sh      <= '0;
      b_sh      <= '0;
      r_sh      <= '0;
      cnt       <= '0;
      bw        <= 1'b0;
      diff      <= '0;
      borrow    <= 1'b0;
      zero      <= 1'b0;
`ifdef SUB_OVF_EN
      overflow  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          // in_ready is always high in IDLE, so in_valid alone completes the handshake
          if (in_valid) begin
            a_sh     <= inA;
            b_sh     <= inB;
            r_sh     <= '0;
            bw       <= 1'b0;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= SHIFT;
          end
        end

        SHIFT: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          r_sh <= r_next;
          bw   <= bw_next;
          cnt  <= cnt + CW'(1);
          if (cnt == LAST_BIT) begin
            // The last cell output is the MSB. The operand LSBs now hold the operand MSBs.
            diff      <= r_next;
            borrow    <= bw_next;
            zero      <= ~|r_next;
`ifdef SUB_OVF_EN
            overflow  <= (a0 ^ b0) & (a0 ^ d_bit);
`endif
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end

        DONE: begin
          // Results and flags stay where they are. Only the handshake bits change.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sub_serial_8bit.sv
// -----------------------------------------------------------------------------
// tb_sub_serial_8bit
// A driver process issues operand pairs. For each one it pushes the expected
// result, built from plain integer arithmetic, into a scoreboard queue. A
// separate monitor pops and compares an entry at every result handshake.
// The driver also checks latency, back-pressure stability and recovery after
// an aborting reset. Build with +define+SUB_OVF_EN to include the overflow check.
// -----------------------------------------------------------------------------
module tb_sub_serial_8bit;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] inA;
  logic [WIDTH-1:0] inB;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             zero;
`ifdef SUB_OVF_EN
  logic             overflow;
`endif

  sub_serial_8bit #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .inA       (inA),
    .inB       (inB),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow    (borrow),
    .zero      (zero)
`ifdef SUB_OVF_EN
    ,
    .overflow  (overflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] d;
    logic             b;
    logic             z;
    logic             v;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Reference model: works on integer values, not on bits
  function automatic exp_t model(input int a, input int b);
    exp_t e;
    int   sa, sb, sd;
    e.d = WIDTH'((a - b + (1 << WIDTH)) % (1 << WIDTH));
    e.b = (a < b);
    e.z = (e.d == 0);
    sa  = (a >= (1 << (WIDTH - 1))) ? a - (1 << WIDTH) : a;
    sb  = (b >= (1 << (WIDTH - 1))) ? b - (1 << WIDTH) : b;
    sd  = sa - sb;
    e.v = (sd > (1 << (WIDTH - 1)) - 1) || (sd < -(1 << (WIDTH - 1)));
    return e;
  endfunction

  // Monitor: checks one scoreboard entry per result handshake. Sampling is on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("unexpected_result", 32'(out_valid), 32'(0));
        end else begin
          e = sb_q.pop_front();
          check("diff",   32'(diff),   32'(e.d));
          check("borrow", 32'(borrow), 32'(e.b));
          check("zero",   32'(zero),   32'(e.z));
`ifdef SUB_OVF_EN
          check("overflow", 32'(overflow), 32'(e.v));
`endif
        end
      end
    end
  end

  // Randomize the operand-side inputs, which the DUT must ignore while busy
  task automatic scramble_inputs();
    inA      = WIDTH'($urandom);
    inB      = WIDTH'($urandom);
    in_valid = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("in_ready_idle", 32'(in_ready), 32'(1));
  endtask

  // Send one operand pair. Hold off the result for 'hold' cycles, then accept it.
  task automatic do_op(input int a, input int b, input int hold);
    int               n;
    logic [WIDTH-1:0] h_d;
    logic             h_b, h_z;
    wait_idle();
    inA      = WIDTH'(a);
    inB      = WIDTH'(b);
    in_valid = 1'b1;
    @(posedge clk); #1;
    sb_q.push_back(model(a, b));
    scramble_inputs();
    check("in_ready_busy", 32'(in_ready), 32'(0));
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      scramble_inputs();
    end while (!out_valid && n < 50);
    check("latency", 32'(n), 32'(WIDTH));
    if (!out_valid) begin
      void'(sb_q.pop_back());
      in_valid = 1'b0;
      return;
    end
    h_d = diff;
    h_b = borrow;
    h_z = zero;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid",    32'(out_valid), 32'(1));
      check("hold_in_ready", 32'(in_ready),  32'(0));
      check("hold_diff",     32'(diff),      32'(h_d));
      check("hold_borrow",   32'(borrow),    32'(h_b));
      check("hold_zero",     32'(zero),      32'(h_z));
      scramble_inputs();
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("valid_drop",     32'(out_valid), 32'(0));
    check("in_ready_after", 32'(in_ready),  32'(1));
    check("diff_kept",      32'(diff),      32'(h_d));
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    inA       = '0;
    inB       = '0;
    out_ready = 1'b0;
    #12;
    check("rst_in_ready",  32'(in_ready),  32'(1));
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_diff",      32'(diff),      32'(0));
    check("rst_borrow",    32'(borrow),    32'(0));
    check("rst_zero",      32'(zero),      32'(0));
`ifdef SUB_OVF_EN
    check("rst_overflow",  32'(overflow),  32'(0));
`endif
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases: plain, unsigned borrow, zero result, signed overflow with long back-pressure
    do_op(8'h05, 8'h03, 0);
    do_op(8'h03, 8'h05, 1);
    do_op(8'h42, 8'h42, 2);
    do_op(8'h80, 8'h01, 5);

    // Abort: assert reset four edges into SHIFT. Outputs must return to reset values at once.
    wait_idle();
    inA      = 8'hFF;
    inB      = 8'h01;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    check("abort_in_ready",  32'(in_ready),  32'(1));
    check("abort_out_valid", 32'(out_valid), 32'(0));
    check("abort_diff",      32'(diff),      32'(0));
    check("abort_borrow",    32'(borrow),    32'(0));
    check("abort_zero",      32'(zero),      32'(0));
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(8'h10, 8'h20, 0);

    // Random operand pairs with random back-pressure
    for (int i = 0; i < 256; i++) begin
      do_op(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
            int'($urandom_range(0, 3)));
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", 32'(sb_q.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
